// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared op codes, FSM states and sizing helpers for the HI/LO unit
package mips_cpu_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIV_RUN = 2'd1,
      DIV_FIX = 2'd2
   } hilo_state_t;

   localparam int HILO_WIDTH = 32;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_width(HILO_WIDTH);

endpackage

// File: rtl/mips_cpu_hilo_unit_if.sv
// rtl/mips_cpu_hilo_unit_if.sv - request/result bundle between decoder and HI/LO unit
interface mips_cpu_hilo_unit_if #(parameter int WIDTH = 32);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/mips_cpu_divider.sv
// rtl/mips_cpu_divider.sv - unsigned restoring divider, one quotient bit per cycle
module mips_cpu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             last_iter
);
   import mips_cpu_pkg::*;

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             active_q;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;

   // Partial remainder needs one extra bit after the shift-in.
   always_comb begin
      trial = {remainder, quotient[WIDTH-1]};
      diff  = trial - {1'b0, dvs_q};
   end

   assign last_iter = active_q && (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         quotient  <= '0;
         remainder <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         active_q  <= 1'b0;
      end else if (load) begin
         quotient  <= dividend;
         remainder <= '0;
         dvs_q     <= divisor;
         cnt_q     <= '0;
         active_q  <= 1'b1;
      end else if (active_q) begin
         if (!diff[WIDTH]) begin
            remainder <= diff[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b1};
         end else begin
            remainder <= trial[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b0};
         end
         cnt_q <= cnt_q + 1'b1;
         if (last_iter)
            active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// rtl/mips_cpu_hilo_unit.sv - MULT/DIV execution stage owning the HI/LO registers
module mips_cpu_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_cpu_hilo_unit_if.slave   bus
);
   import mips_cpu_pkg::*;

   hilo_state_t      state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_load;

   logic             qneg_q, rneg_q, dzero_q;
   logic [WIDTH-1:0] rs_raw_q;

   logic             accept;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [2*WIDTH-1:0] ext_a, ext_b, product;
   logic [WIDTH-1:0] div_q, div_r;
   logic             div_last;

   assign accept = bus.start && !busy_q;

   // Signed divide works on magnitudes; 0x80000000 maps to itself, which is the right unsigned value.
   always_comb begin
      a_neg   = (bus.op == OP_DIV) && bus.rs_data[WIDTH-1];
      b_neg   = (bus.op == OP_DIV) && bus.rt_data[WIDTH-1];
      a_mag   = a_neg ? -bus.rs_data : bus.rs_data;
      b_mag   = b_neg ? -bus.rt_data : bus.rt_data;
      ext_a   = {{WIDTH{(bus.op == OP_MULT) && bus.rs_data[WIDTH-1]}}, bus.rs_data};
      ext_b   = {{WIDTH{(bus.op == OP_MULT) && bus.rt_data[WIDTH-1]}}, bus.rt_data};
      product = ext_a * ext_b;
   end

   mips_cpu_divider #(.WIDTH(WIDTH)) u_divider (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_q),
      .remainder (div_r),
      .last_iter (div_last)
   );

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      div_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (bus.op)
                  OP_MULT, OP_MULTU: begin
                     {hi_d, lo_d} = product;
                     done_d       = 1'b1;
                  end
                  OP_MTHI: hi_d = bus.rs_data;
                  OP_MTLO: lo_d = bus.rs_data;
                  OP_DIV, OP_DIVU: begin
                     div_load = 1'b1;
                     busy_d   = 1'b1;
                     state_d  = DIV_RUN;
                  end
                  default: ;
               endcase
            end
         end
         DIV_RUN: begin
            if (div_last)
               state_d = DIV_FIX;
         end
         DIV_FIX: begin
            if (dzero_q) begin
               hi_d = rs_raw_q;
               lo_d = '1;
            end else begin
               hi_d = rneg_q ? -div_r : div_r;
               lo_d = qneg_q ? -div_q : div_q;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dzero_q  <= 1'b0;
         rs_raw_q <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         if (div_load) begin
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            dzero_q  <= (bus.rt_data == '0);
            rs_raw_q <= bus.rs_data;
         end
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// tb/tb_mips_cpu_hilo_unit.sv - scoreboard bench for the HI/LO multiply/divide unit
module tb_mips_cpu_hilo_unit;
   import mips_cpu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mips_cpu_hilo_unit_if #(.WIDTH(W)) bus ();

   mips_cpu_hilo_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_fail = 0;
   logic [63:0] sb[$];
   logic [63:0] mon_exp;
   int pulses;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      bus.start   = 1'b1;
      bus.op      = o;
      bus.rs_data = a;
      bus.rt_data = b;
      step();
      bus.start = 1'b0;
   endtask

   // Entered in cycle 1 of a divide; leaves in the done cycle (cycle 34).
   task automatic div_timed(input string name);
      for (int k = 1; k <= 33; k++) begin
         chk({name, " busy/done"}, {62'b0, bus.busy, bus.done}, 64'd2);
         step();
      end
      chk({name, " done cycle"}, {62'b0, bus.busy, bus.done}, 64'd1);
   endtask

   always @(negedge clk) begin
      if (!reset && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious done", {63'b0, bus.done}, 64'd0);
         end else begin
            mon_exp = sb.pop_front();
            chk("result hi:lo", {bus.hi, bus.lo}, mon_exp);
            chk("busy at done", {63'b0, bus.busy}, 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.start   = 1'b0;
      bus.op      = 3'd0;
      bus.rs_data = '0;
      bus.rt_data = '0;
      reset       = 1'b1;
      step();
      step();
      chk("reset hi", bus.hi, 64'd0);
      chk("reset lo", bus.lo, 64'd0);
      chk("reset busy/done", {62'b0, bus.busy, bus.done}, 64'd0);
      reset = 1'b0;

      issue(OP_MTLO, 32'h12345678, 32'h0);
      chk("mtlo lo", bus.lo, 64'h12345678);
      chk("mtlo hi", bus.hi, 64'd0);
      chk("mtlo done", {63'b0, bus.done}, 64'd0);

      sb.push_back(64'hFFFFFFFF_FFFFFFFA);
      issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
      chk("mult busy/done", {62'b0, bus.busy, bus.done}, 64'd1);
      sb.push_back(64'h00000002_FFFFFFFA);
      issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
      chk("multu busy/done", {62'b0, bus.busy, bus.done}, 64'd1);

      sb.push_back({32'd2, 32'd14});
      issue(OP_DIVU, 32'd100, 32'd7);
      div_timed("divu 100/7");

      sb.push_back(64'hFFFFFFFF_FFFFFFFD);
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      div_timed("div -7/2");

      sb.push_back(64'h00001234_FFFFFFFF);
      issue(OP_DIVU, 32'h1234, 32'd0);
      div_timed("divu by zero");

      sb.push_back(64'h00000000_80000000);
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      div_timed("div overflow");

      // Busy collision: MTHI offered mid-divide must be dropped.
      issue(OP_MTHI, 32'h0000AAAA, 32'h0);
      chk("mthi preload", bus.hi, 64'h0000AAAA);
      sb.push_back({32'd2, 32'd14});
      issue(OP_DIVU, 32'd100, 32'd7);
      for (int k = 1; k <= 33; k++) begin
         if (k == 6) bus.start = 1'b0;
         chk("collision hi held", bus.hi, 64'h0000AAAA);
         chk("collision busy/done", {62'b0, bus.busy, bus.done}, 64'd2);
         if (k == 5) begin
            bus.start   = 1'b1;
            bus.op      = OP_MTHI;
            bus.rs_data = 32'h00005555;
         end
         step();
      end
      chk("collision hi final", bus.hi, 64'd2);
      chk("collision done", {62'b0, bus.busy, bus.done}, 64'd1);
      sb.push_back(64'h00000001_00000000);
      issue(OP_MULT, 32'h00010000, 32'h00010000);
      chk("b2b mult done", {62'b0, bus.busy, bus.done}, 64'd1);
      chk("b2b mult hi", bus.hi, 64'd1);

      // Reset abort during a divide.
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort busy", {63'b0, bus.busy}, 64'd0);
      chk("abort hi:lo", {bus.hi, bus.lo}, 64'd0);
      pulses = 0;
      repeat (40) begin
         if (bus.done) pulses++;
         step();
      end
      chk("abort no done", pulses, 64'd0);

      issue(3'd7, 32'hDEAD, 32'hBEEF);
      chk("reserved hi:lo", {bus.hi, bus.lo}, 64'd0);
      chk("reserved busy/done", {62'b0, bus.busy, bus.done}, 64'd0);

      step();
      chk("scoreboard drained", sb.size(), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
